// File: rtl/uart_disp_pkg.sv
// Shared definitions for the UART-to-display path: ASCII control codes,
// hex character decoding and the entry FSM encoding.
package uart_disp_pkg;

    localparam logic [7:0] ASC_CR  = 8'h0D;
    localparam logic [7:0] ASC_LF  = 8'h0A;
    localparam logic [7:0] ASC_ESC = 8'h1B;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ENTRY = 1'b1
    } entry_state_t;

    // Returns {is_hex, val}; val is 0 when the character is not a hex digit.
    function automatic logic [4:0] ascii_to_hex(input logic [7:0] c);
        logic [4:0] r;
        r = 5'd0;
        if (c >= 8'h30 && c <= 8'h39)
            r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

endpackage

// File: rtl/idle_timer.sv
// Idle timer: counts while run is high, restarts on kick, and flags expire
// on the terminal cycle unless a kick arrives in that same cycle.
module idle_timer #(
    parameter int unsigned CLK_FREQ   = 50,
    parameter int unsigned TIMEOUT_MS = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic kick,
    output logic expire
);

    // Terminal count is computed wide and must fit in 32 bits.
    localparam longint unsigned TERM_L =
        longint'(TIMEOUT_MS) * longint'(CLK_FREQ) * 64'd1000 - 64'd1;
    localparam logic [31:0] TERM = TERM_L[31:0];

    logic [31:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !run || kick)
            cnt <= 32'd0;
        else if (cnt == TERM)
            cnt <= 32'd0;
        else
            cnt <= cnt + 32'd1;
    end

    assign expire = run && !kick && (cnt == TERM);

endmodule

// File: rtl/uart_hex_entry.sv
// Collects ASCII hex digits from the UART receiver and commits the last four
// to the 7-segment driver on CR/LF; ESC or an idle timeout discards the entry.
module uart_hex_entry
    import uart_disp_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50,
    parameter int unsigned TIMEOUT_MS = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       upd,
    output logic       err,
    output logic       busy
);

    // rx_valid is a one-cycle strobe with no ready: every strobed byte is
    // consumed in the cycle it appears, back-to-back strobes included.
    entry_state_t state, state_n;
    logic [15:0]  stg, stg_n;
    logic [2:0]   cnt, cnt_n;
    logic [15:0]  disp, disp_n;
    logic         upd_n, err_n;
    logic         expire;
    logic [4:0]   hex;

    idle_timer #(
        .CLK_FREQ   (CLK_FREQ),
        .TIMEOUT_MS (TIMEOUT_MS)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state == ST_ENTRY),
        .kick   (rx_valid),
        .expire (expire)
    );

    assign hex = ascii_to_hex(rx_data);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            stg   <= 16'd0;
            cnt   <= 3'd0;
            disp  <= 16'd0;
            upd   <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_n;
            stg   <= stg_n;
            cnt   <= cnt_n;
            disp  <= disp_n;
            upd   <= upd_n;
            err   <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        stg_n   = stg;
        cnt_n   = cnt;
        disp_n  = disp;
        upd_n   = 1'b0;
        err_n   = 1'b0;
        if (rx_valid) begin
            if (hex[4]) begin
                stg_n   = {stg[11:0], hex[3:0]};
                cnt_n   = (cnt == 3'd4) ? 3'd4 : cnt + 3'd1;
                state_n = ST_ENTRY;
            end else if (rx_data == ASC_CR || rx_data == ASC_LF) begin
                // A terminator with nothing staged (e.g. LF of CRLF) is silent.
                if (state == ST_ENTRY) begin
                    disp_n  = stg;
                    upd_n   = 1'b1;
                    stg_n   = 16'd0;
                    cnt_n   = 3'd0;
                    state_n = ST_IDLE;
                end
            end else if (rx_data == ASC_ESC) begin
                stg_n   = 16'd0;
                cnt_n   = 3'd0;
                state_n = ST_IDLE;
            end else begin
                err_n = 1'b1;
            end
        end else if (expire) begin
            stg_n   = 16'd0;
            cnt_n   = 3'd0;
            state_n = ST_IDLE;
        end
    end

    assign {d3, d2, d1, d0} = disp;
    assign busy = (state == ST_ENTRY);

endmodule
